// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, synchronises and debounces the
// column returns, and presents the last accepted key as a sticky 4-bit code.
//
// Ports:
//   clk        in   system clock (single domain)
//   rst        in   synchronous, active-high reset
//   col[3:0]   in   raw keypad columns, pulled up, active-low, asynchronous
//   row[3:0]   out  registered row drive, active-low
//   key_data   out  code of the last accepted key (cleared only by reset)
//   key_valid  out  high while the accepted key is held
//   key_pulse  out  one-cycle strobe when a press is accepted
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        DEBOUNCE = 2'd2,
        HELD     = 2'd3
    } state_t;

    // Keypad legend: rows 0..2 are digits plus A/B/C, row 3 is *,0,#,D
    // with * and # encoded as E and F.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Index of the lowest column that is pulled low (lowest column wins).
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0]) begin
            idx = 2'd0;
        end else if (!c[1]) begin
            idx = 2'd1;
        end else if (!c[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Active-low drive pattern for a single selected row.
    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] drv;
        case (r)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            2'd3:    drv = 4'b0111;
            default: drv = 4'b1111;
        endcase
        return drv;
    endfunction

    logic [3:0]       col_m_q, col_s_q;
    state_t           state_q, state_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       key_data_q, key_data_d;
    logic             key_valid_q, key_valid_d;
    logic             key_pulse_q, key_pulse_d;

    // Two-flop synchroniser for the asynchronous column inputs; idles at
    // "no key" so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m_q <= 4'hF;
            col_s_q <= 4'hF;
        end else begin
            col_m_q <= col;
            col_s_q <= col_m_q;
        end
    end

    // Next-state, counter and output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        key_data_d  = key_data_q;
        key_valid_d = key_valid_q;
        key_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                // All rows driven low, so any key shows up on col_s.
                if (col_s_q != 4'hF) begin
                    state_d   = SCAN;
                    row_idx_d = 2'd0;
                    div_d     = '0;
                end else begin
                    div_d = '0;
                end
            end
            SCAN: begin
                // Sampling at the end of the row window leaves room for the
                // synchroniser to reflect this row's drive.
                if (div_q == DIV_LAST) begin
                    if (col_s_q != 4'hF) begin
                        col_idx_d = lowest_low(col_s_q);
                        cnt_d     = '0;
                        div_d     = '0;
                        state_d   = DEBOUNCE;
                    end else if (row_idx_q == 2'd3) begin
                        div_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        div_d     = '0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!col_s_q[col_idx_q]) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = HELD;
                        cnt_d       = '0;
                        key_data_d  = key_code(row_idx_q, col_idx_q);
                        key_valid_d = 1'b1;
                        key_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Bounce: abandon this candidate and rescan from scratch.
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (col_s_q[col_idx_q]) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        key_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Bounce on release only restarts the release count.
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Row drive is registered and follows the state being entered.
        case (state_d)
            IDLE:     row_d = 4'b0000;
            SCAN:     row_d = row_drive(row_idx_d);
            DEBOUNCE: row_d = row_drive(row_idx_d);
            HELD:     row_d = row_drive(row_idx_d);
            default:  row_d = 4'b0000;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            div_q       <= '0;
            cnt_q       <= '0;
            row_q       <= 4'b0000;
            key_data_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign row       = row_q;
    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_pulse = key_pulse_q;

endmodule
